// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_bank_clr family: FSM encoding and lane-masked merge.
// Combinational only; there is no timing or backpressure here.
package ram_pkg;

  typedef enum logic {
    RAM_READY = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_state_t;

  // Widest data word lane_merge can serve; callers zero-extend and truncate.
  localparam int RAM_MAX_DBITS = 1024;
  localparam int RAM_IDX_BITS  = $clog2(RAM_MAX_DBITS);

  // Bit b takes new_d when its lane (b / lane) is enabled in mask, else keeps old_d.
  function automatic logic [RAM_MAX_DBITS-1:0] lane_merge(
    input logic [RAM_MAX_DBITS-1:0] old_d,
    input logic [RAM_MAX_DBITS-1:0] new_d,
    input logic [RAM_MAX_DBITS-1:0] mask,
    input int                       lane
  );
    logic [RAM_MAX_DBITS-1:0] res;
    logic [RAM_IDX_BITS-1:0]  bit_idx;
    logic [RAM_IDX_BITS-1:0]  lane_idx;
    res = old_d;
    for (int b = 0; b < RAM_MAX_DBITS; b++) begin
      bit_idx  = RAM_IDX_BITS'(b);
      lane_idx = RAM_IDX_BITS'(b / lane);
      if (mask[lane_idx]) res[bit_idx] = new_d[bit_idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_bank_clr_outreg.sv
// ram_outreg: one register stage carrying {valid, data} for a RAM read port.
// Latency 1; free-running capture, no backpressure.
module ram_outreg #(
  parameter int DBITS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DBITS:0] din,
  output logic [DBITS:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst) dout <= '0;
    else      dout <= din;
  end

endmodule

// File: rtl/ram_bank_clr.sv
// ram_bank_clr: 1RW+1R RAM with lane write mask, read-first port 0, port-1 write forwarding and a zeroing sequencer.
// Read latency 1 (2 with OUTREG); no backpressure, every access is dropped while busy.
module ram_bank_clr
  import ram_pkg::*;
#(
  parameter int DBITS      = 64,
  parameter int ABITS      = 6,
  parameter int LANE       = 8,
  parameter int OUTREG     = 0,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ABITS-1:0]      addr0,
  input  logic                  re0,
  output logic [DBITS-1:0]      rd0,
  output logic                  rv0,
  input  logic [DBITS-1:0]      wr0,
  input  logic [DBITS/LANE-1:0] wmask0,
  input  logic                  we0,
  input  logic [ABITS-1:0]      addr1,
  input  logic                  re1,
  output logic [DBITS-1:0]      rd1,
  output logic                  rv1,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int DEPTH = 1 << ABITS;

  logic [DBITS-1:0] mem [DEPTH];

  ram_state_t       state, state_nxt;
  logic [ABITS-1:0] cnt, cnt_nxt;

  logic             rd_en0, rd_en1, wr_en0;
  logic [DBITS-1:0] old0, old1, wr0_merged, rd1_src;
  logic [DBITS-1:0] s1_rd0, s1_rd1;
  logic             s1_rv0, s1_rv1;

  assign busy   = (state == RAM_CLEAR);
  assign rd_en0 = !busy && re0;
  assign rd_en1 = !busy && re1;
  assign wr_en0 = !busy && we0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= (CLR_ON_RST != 0) ? RAM_CLEAR : RAM_READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RAM_READY: begin
        if (clr_req) begin
          state_nxt = RAM_CLEAR;
          cnt_nxt   = '0;
        end
      end
      RAM_CLEAR: begin
        cnt_nxt = cnt + ABITS'(1);
        if (cnt == ABITS'(DEPTH - 1)) state_nxt = RAM_READY;
      end
      default: state_nxt = RAM_READY;
    endcase
  end

  assign old0 = mem[addr0];
  assign old1 = mem[addr1];

  // The same merged word feeds both the array write and the port-1 forward path.
  assign wr0_merged = DBITS'(lane_merge(RAM_MAX_DBITS'(old0), RAM_MAX_DBITS'(wr0),
                                        RAM_MAX_DBITS'(wmask0), LANE));

  assign rd1_src = (BYPASS != 0 && wr_en0 && addr0 == addr1) ? wr0_merged : old1;

  // Array has no reset; contents are left alone while rst is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (busy)        mem[cnt]   <= '0;
      else if (wr_en0) mem[addr0] <= wr0_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_rd0 <= '0;
      s1_rd1 <= '0;
      s1_rv0 <= 1'b0;
      s1_rv1 <= 1'b0;
    end else begin
      s1_rv0 <= rd_en0;
      s1_rv1 <= rd_en1;
      if (rd_en0) s1_rd0 <= old0;
      if (rd_en1) s1_rd1 <= rd1_src;
    end
  end

  if (OUTREG != 0) begin : g_outreg
    ram_outreg #(.DBITS(DBITS)) u_out0 (
      .clk  (clk),
      .rst  (rst),
      .din  ({s1_rv0, s1_rd0}),
      .dout ({rv0, rd0})
    );
    ram_outreg #(.DBITS(DBITS)) u_out1 (
      .clk  (clk),
      .rst  (rst),
      .din  ({s1_rv1, s1_rd1}),
      .dout ({rv1, rd1})
    );
  end else begin : g_direct
    assign {rv0, rd0} = {s1_rv0, s1_rd0};
    assign {rv1, rd1} = {s1_rv1, s1_rd1};
  end

endmodule

// File: tb/tb_ram_bank_clr.sv
// Bench for ram_bank_clr: instance a (OUTREG=0, BYPASS=1) and instance b (OUTREG=1, BYPASS=0) share stimulus.
// A behavioural memory model predicts both; b is a one-cycle-later copy of a non-forwarding port.
module tb_ram_bank_clr;

  localparam int DBITS = 64;
  localparam int ABITS = 6;
  localparam int LANE  = 8;
  localparam int MBITS = DBITS / LANE;
  localparam int DEPTH = 1 << ABITS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [ABITS-1:0] addr0, addr1;
  logic             re0, we0, re1, clr_req;
  logic [DBITS-1:0] wr0;
  logic [MBITS-1:0] wmask0;
  logic [DBITS-1:0] rd0_a, rd1_a, rd0_b, rd1_b;
  logic             rv0_a, rv1_a, rv0_b, rv1_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_bank_clr #(.DBITS(DBITS), .ABITS(ABITS), .LANE(LANE), .OUTREG(0), .BYPASS(1), .CLR_ON_RST(1)) u_dut_a (
    .clk(clk), .rst(rst), .addr0(addr0), .re0(re0), .rd0(rd0_a), .rv0(rv0_a), .wr0(wr0),
    .wmask0(wmask0), .we0(we0), .addr1(addr1), .re1(re1), .rd1(rd1_a), .rv1(rv1_a),
    .clr_req(clr_req), .busy(busy_a)
  );

  ram_bank_clr #(.DBITS(DBITS), .ABITS(ABITS), .LANE(LANE), .OUTREG(1), .BYPASS(0), .CLR_ON_RST(1)) u_dut_b (
    .clk(clk), .rst(rst), .addr0(addr0), .re0(re0), .rd0(rd0_b), .rv0(rv0_b), .wr0(wr0),
    .wmask0(wmask0), .we0(we0), .addr1(addr1), .re1(re1), .rd1(rd1_b), .rv1(rv1_b),
    .clr_req(clr_req), .busy(busy_b)
  );

  // Reference model: memory array, remaining clear cycles, expected port outputs.
  logic [DBITS-1:0] m_mem [DEPTH];
  int               m_left = DEPTH;
  int               m_ptr  = 0;
  logic [DBITS-1:0] xa_rd0 = '0, xa_rd1 = '0, xn_rd1 = '0, xb_rd0 = '0, xb_rd1 = '0;
  logic             xa_rv0 = 1'b0, xa_rv1 = 1'b0, xb_rv0 = 1'b0, xb_rv1 = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  always @(posedge clk) begin : model
    logic [DBITS-1:0] new_w;
    if (!rst) begin
      m_left = DEPTH; m_ptr = 0;
      xa_rd0 = '0; xa_rd1 = '0; xn_rd1 = '0; xb_rd0 = '0; xb_rd1 = '0;
      xa_rv0 = 1'b0; xa_rv1 = 1'b0; xb_rv0 = 1'b0; xb_rv1 = 1'b0;
    end else begin
      xb_rd0 = xa_rd0; xb_rv0 = xa_rv0; xb_rd1 = xn_rd1; xb_rv1 = xa_rv1;
      if (m_left > 0) begin
        m_mem[m_ptr] = '0;
        m_ptr++;
        m_left--;
        xa_rv0 = 1'b0;
        xa_rv1 = 1'b0;
      end else begin
        new_w = m_mem[addr0];
        for (int i = 0; i < MBITS; i++)
          if (wmask0[i]) new_w[i*LANE +: LANE] = wr0[i*LANE +: LANE];
        xa_rv0 = re0;
        xa_rv1 = re1;
        if (re0) xa_rd0 = m_mem[addr0];
        if (re1) begin
          xn_rd1 = m_mem[addr1];
          xa_rd1 = (we0 && addr1 == addr0) ? new_w : m_mem[addr1];
        end
        if (we0) m_mem[addr0] = new_w;
        if (clr_req) begin m_left = DEPTH; m_ptr = 0; end
      end
    end
  end

  task automatic idle();
    re0 = 1'b0; we0 = 1'b0; re1 = 1'b0; clr_req = 1'b0;
    addr0 = '0; addr1 = '0; wr0 = '0; wmask0 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write0(input int a, input logic [DBITS-1:0] d, input logic [MBITS-1:0] m);
    idle(); we0 = 1'b1; addr0 = ABITS'(a); wr0 = d; wmask0 = m;
    tick();
    idle();
  endtask

  task automatic test_reset();
    int busy_cycles, guard;
    bit rv_seen;
    idle(); rst = 1'b0;
    tick(); tick();
    n_cmp++;
    if (rd0_a !== '0 || rd1_a !== '0 || rv0_a !== 1'b0 || rv1_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs_a: rd0=%h rd1=%h rv0=%b rv1=%b, required all zero", rd0_a, rd1_a, rv0_a, rv1_a);
    end
    n_cmp++;
    if (rd0_b !== '0 || rd1_b !== '0 || rv0_b !== 1'b0 || rv1_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs_b: rd0=%h rd1=%h rv0=%b rv1=%b, required all zero", rd0_b, rd1_b, rv0_b, rv1_b);
    end
    n_cmp++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_busy: got a=%b b=%b, required 1", busy_a, busy_b);
    end
    rst = 1'b1; re1 = 1'b1; addr1 = ABITS'(5);
    busy_cycles = 0; guard = 0; rv_seen = 1'b0;
    while (busy_a === 1'b1 && guard < 200) begin
      busy_cycles++;
      if (rv1_a !== 1'b0 || rv1_b !== 1'b0) rv_seen = 1'b1;
      tick();
      guard++;
    end
    n_cmp++;
    if (busy_cycles != DEPTH) begin
      n_bad++;
      $display("FAIL post_reset_busy_len: got %0d cycles, required %0d", busy_cycles, DEPTH);
    end
    n_cmp++;
    if (rv_seen) begin
      n_bad++;
      $display("FAIL rv1_during_clear: got a strobe, required none");
    end
    tick();
    n_cmp++;
    if (rv1_a !== 1'b1 || rd1_a !== '0) begin
      n_bad++;
      $display("FAIL first_read_after_clear_a: rv1=%b rd1=%h, required 1 / 0", rv1_a, rd1_a);
    end
    re1 = 1'b0;
    tick();
    n_cmp++;
    if (rv1_b !== 1'b1 || rd1_b !== '0 || rv1_a !== 1'b0) begin
      n_bad++;
      $display("FAIL first_read_after_clear_b: rv1_b=%b rd1_b=%h rv1_a=%b, required 1 / 0 / 0", rv1_b, rd1_b, rv1_a);
    end
  endtask

  task automatic test_masked_write();
    write0(3, 64'h1122334455667788, 8'hFF);
    write0(3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    re0 = 1'b1; addr0 = ABITS'(3);
    tick();
    idle();
    n_cmp++;
    if (rv0_a !== 1'b1 || rd0_a !== 64'h11223344AAAAAAAA) begin
      n_bad++;
      $display("FAIL masked_write_a: rv0=%b rd0=%h, required 1 / 11223344aaaaaaaa", rv0_a, rd0_a);
    end
    tick();
    n_cmp++;
    if (rv0_a !== 1'b0 || rd0_a !== 64'h11223344AAAAAAAA) begin
      n_bad++;
      $display("FAIL rv0_strobe_hold: rv0=%b rd0=%h, required 0 / 11223344aaaaaaaa", rv0_a, rd0_a);
    end
    n_cmp++;
    if (rv0_b !== 1'b1 || rd0_b !== 64'h11223344AAAAAAAA) begin
      n_bad++;
      $display("FAIL masked_write_b: rv0=%b rd0=%h, required 1 / 11223344aaaaaaaa", rv0_b, rd0_b);
    end
  endtask

  task automatic test_read_first();
    write0(7, 64'h1, 8'hFF);
    re0 = 1'b1; we0 = 1'b1; addr0 = ABITS'(7); wr0 = 64'h2; wmask0 = 8'hFF;
    tick();
    idle();
    n_cmp++;
    if (rd0_a !== 64'h1 || rv0_a !== 1'b1) begin
      n_bad++;
      $display("FAIL read_first_old: rd0=%h rv0=%b, required 1 / 1", rd0_a, rv0_a);
    end
    re0 = 1'b1; addr0 = ABITS'(7);
    tick();
    idle();
    n_cmp++;
    if (rd0_a !== 64'h2) begin
      n_bad++;
      $display("FAIL read_first_commit: rd0=%h, required 2", rd0_a);
    end
  endtask

  task automatic test_bypass();
    write0(9, 64'h0, 8'hFF);
    we0 = 1'b1; addr0 = ABITS'(9); wr0 = 64'hFF00; wmask0 = 8'h02;
    re1 = 1'b1; addr1 = ABITS'(9);
    tick();
    idle();
    n_cmp++;
    if (rd1_a !== 64'hFF00 || rv1_a !== 1'b1) begin
      n_bad++;
      $display("FAIL bypass_on: rd1=%h rv1=%b, required ff00 / 1", rd1_a, rv1_a);
    end
    tick();
    n_cmp++;
    if (rd1_b !== 64'h0 || rv1_b !== 1'b1) begin
      n_bad++;
      $display("FAIL bypass_off: rd1=%h rv1=%b, required 0 / 1", rd1_b, rv1_b);
    end
  endtask

  task automatic test_outreg();
    logic [5:0] pat_a, pat_b;
    for (int i = 0; i < 3; i++) write0(i, DBITS'(64'hA + i), 8'hFF);
    pat_a = '0; pat_b = '0;
    for (int j = 0; j < 6; j++) begin
      idle();
      if (j < 3) begin re1 = 1'b1; addr1 = ABITS'(j); end
      tick();
      pat_a[j] = rv1_a;
      pat_b[j] = rv1_b;
      if (j >= 1 && j <= 3) begin
        n_cmp++;
        if (rd1_b !== DBITS'(64'hA + j - 1)) begin
          n_bad++;
          $display("FAIL outreg_data_%0d: rd1=%h, required %h", j, rd1_b, 64'hA + j - 1);
        end
      end
    end
    idle();
    n_cmp++;
    if (pat_b !== 6'b001110) begin
      n_bad++;
      $display("FAIL outreg_rv_pattern: got %b, required 001110", pat_b);
    end
    n_cmp++;
    if (pat_a !== 6'b000111) begin
      n_bad++;
      $display("FAIL direct_rv_pattern: got %b, required 000111", pat_a);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 600; c++) begin
      re0     = ($urandom_range(0, 3) != 0);
      re1     = ($urandom_range(0, 3) != 0);
      we0     = ($urandom_range(0, 1) != 0);
      addr0   = ABITS'($urandom_range(0, 15));
      addr1   = ($urandom_range(0, 2) == 0) ? addr0 : ABITS'($urandom_range(0, 15));
      wr0     = {$urandom, $urandom};
      wmask0  = MBITS'($urandom);
      clr_req = ($urandom_range(0, 199) == 0);
      tick();
      n_cmp++;
      if (busy_a !== (m_left > 0) || busy_b !== (m_left > 0)) begin
        n_bad++;
        $display("FAIL rand_busy c%0d: a=%b b=%b, required %b", c, busy_a, busy_b, m_left > 0);
      end
      n_cmp++;
      if (rv0_a !== xa_rv0 || rd0_a !== xa_rd0) begin
        n_bad++;
        $display("FAIL rand_p0_a c%0d: rv=%b rd=%h, required %b / %h", c, rv0_a, rd0_a, xa_rv0, xa_rd0);
      end
      n_cmp++;
      if (rv1_a !== xa_rv1 || rd1_a !== xa_rd1) begin
        n_bad++;
        $display("FAIL rand_p1_a c%0d: rv=%b rd=%h, required %b / %h", c, rv1_a, rd1_a, xa_rv1, xa_rd1);
      end
      n_cmp++;
      if (rv0_b !== xb_rv0 || rd0_b !== xb_rd0) begin
        n_bad++;
        $display("FAIL rand_p0_b c%0d: rv=%b rd=%h, required %b / %h", c, rv0_b, rd0_b, xb_rv0, xb_rd0);
      end
      n_cmp++;
      if (rv1_b !== xb_rv1 || rd1_b !== xb_rd1) begin
        n_bad++;
        $display("FAIL rand_p1_b c%0d: rv=%b rd=%h, required %b / %h", c, rv1_b, rd1_b, xb_rv1, xb_rd1);
      end
    end
    idle();
    for (int g = 0; g < 100 && busy_a === 1'b1; g++) tick();
  endtask

  task automatic test_clear_reset();
    int busy_cycles, guard;
    for (int i = 0; i < DEPTH; i++) write0(i, {$urandom, $urandom} | 64'h1, 8'hFF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_req_busy: got %b, required 1", busy_a);
    end
    repeat (19) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    busy_cycles = 0; guard = 0;
    while (busy_a === 1'b1 && guard < 200) begin
      busy_cycles++;
      tick();
      guard++;
    end
    n_cmp++;
    if (busy_cycles != DEPTH) begin
      n_bad++;
      $display("FAIL restart_busy_len: got %0d cycles, required %0d", busy_cycles, DEPTH);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      idle();
      if (i < DEPTH) begin
        re0 = 1'b1; addr0 = ABITS'(i);
        re1 = 1'b1; addr1 = ABITS'(DEPTH - 1 - i);
      end
      tick();
      n_cmp++;
      if (rv0_a !== 1'b1 || rd0_a !== '0 || rv1_a !== 1'b1 || rd1_a !== '0) begin
        n_bad++;
        $display("FAIL cleared_word %0d: rv0=%b rd0=%h rv1=%b rd1=%h, required 1/0/1/0",
                 i, rv0_a, rd0_a, rv1_a, rd1_a);
      end
      if (i == DEPTH - 1) break;
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_masked_write();
    test_read_first();
    test_bypass();
    test_outreg();
    test_back_to_back();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
